branch_detector_multi: RTL

Per-thread multi-entry branch detector for the multithreaded Octavo pipeline. It holds BRANCH_COUNT independently configured branches per thread. Each cycle it compares the current thread's PC and the previous instruction's condition flags against those branches, then emits reached, destination, jump and cancel for the highest-priority matching entry. It sits beside the Controller, and its outputs feed PC selection and ALU cancellation.

---
 rtl/branch_detector_multi.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/branch_detector_multi.sv
// Per-thread multi-entry branch detector: four-stage pipeline, one thread per cycle.
// Define BRANCH_DETECTOR_HIT_COUNT_EN to add the saturating hit_count output.
module branch_detector_multi #(
    parameter int unsigned  PC_WIDTH     = 10,
    parameter int unsigned  FLAG_COUNT   = 8,
    parameter int unsigned  THREAD_COUNT = 8,
    parameter int unsigned  BRANCH_COUNT = 4,
    parameter int unsigned  WORD_WIDTH   = 36,
    localparam int unsigned CFG_WIDTH    = 2 * PC_WIDTH + 2 * FLAG_COUNT + 5,
    localparam int unsigned ENTRY_WIDTH  = (BRANCH_COUNT > 1) ? $clog2(BRANCH_COUNT) : 1,
    localparam int unsigned THREAD_WIDTH = $clog2(THREAD_COUNT)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [FLAG_COUNT-1:0]  flags_previous,
    input  logic                   configuration_wren,
    input  logic [ENTRY_WIDTH-1:0] configuration_entry,
    input  logic [WORD_WIDTH-1:0]  configuration_data,
    input  logic                   IO_ready_previous,
    output logic                   reached,
    output logic [PC_WIDTH-1:0]    destination,
    output logic                   jump,
    output logic                   cancel,
`ifdef BRANCH_DETECTOR_HIT_COUNT_EN
    output logic [15:0]            hit_count,
`endif
    output logic [ENTRY_WIDTH-1:0] entry_index
);

    localparam int unsigned VAL_LSB   = 0;
    localparam int unsigned MASK_LSB  = FLAG_COUNT;
    localparam int unsigned MODE_BIT  = 2 * FLAG_COUNT;
    localparam int unsigned PT_BIT    = MODE_BIT + 1;
    localparam int unsigned PE_BIT    = MODE_BIT + 2;
    localparam int unsigned DEST_LSB  = MODE_BIT + 3;
    localparam int unsigned ORIG_LSB  = DEST_LSB + PC_WIDTH;
    localparam int unsigned OE_BIT    = ORIG_LSB + PC_WIDTH;
    localparam int unsigned VALID_BIT = OE_BIT + 1;

    typedef struct packed {
        logic                   reached;
        logic [ENTRY_WIDTH-1:0] idx;
        logic [PC_WIDTH-1:0]    dest;
        logic                   pred;
        logic                   pe;
        logic                   pt;
        logic [THREAD_WIDTH-1:0] thr;
    } sel_t;

    logic [THREAD_WIDTH-1:0] tc_q, tc_d;
    logic [CFG_WIDTH-1:0]    cfg_q [THREAD_COUNT][BRANCH_COUNT];
    logic [CFG_WIDTH-1:0]    cfg_wdata;
    logic [CFG_WIDTH-1:0]    cfg_s1_q [BRANCH_COUNT];
    logic [PC_WIDTH-1:0]     pc_s1_q;
    logic [FLAG_COUNT-1:0]   flags_s1_q;
    logic [THREAD_WIDTH-1:0] thr_s1_q;
    logic [BRANCH_COUNT-1:0] match, pred_vec;
    logic [FLAG_COUNT-1:0]   diff, mask;
    sel_t                    sel_d, sel_s2_q, sel_s3_q;
    logic [THREAD_COUNT-1:0] saved_q;
    logic                    p_sel, jump_d, cancel_d;

    // Narrow configuration words are zero-extended; spare upper bits are ignored.
    if (WORD_WIDTH >= CFG_WIDTH) begin : g_wide
        assign cfg_wdata = configuration_data[CFG_WIDTH-1:0];
        if (WORD_WIDTH > CFG_WIDTH) begin : g_spare
            logic unused_spare;
            assign unused_spare = ^configuration_data[WORD_WIDTH-1:CFG_WIDTH];
        end
    end else begin : g_narrow
        assign cfg_wdata = {{(CFG_WIDTH - WORD_WIDTH){1'b0}}, configuration_data};
    end

    always_comb begin
        tc_d = (tc_q == THREAD_WIDTH'(THREAD_COUNT - 1)) ? '0 : tc_q + THREAD_WIDTH'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < int'(THREAD_COUNT); t++) begin
                for (int b = 0; b < int'(BRANCH_COUNT); b++) begin
                    cfg_q[t][b] <= '0;
                end
            end
        end else if (configuration_wren && (32'(configuration_entry) < BRANCH_COUNT)) begin
            cfg_q[tc_q][configuration_entry] <= cfg_wdata;
        end
    end

    always_comb begin
        match    = '0;
        pred_vec = '0;
        diff     = '0;
        mask     = '0;
        for (int i = 0; i < int'(BRANCH_COUNT); i++) begin
            diff        = flags_s1_q ^ cfg_s1_q[i][VAL_LSB +: FLAG_COUNT];
            mask        = cfg_s1_q[i][MASK_LSB +: FLAG_COUNT];
            match[i]    = cfg_s1_q[i][VALID_BIT] &
                          (~cfg_s1_q[i][OE_BIT] | (pc_s1_q == cfg_s1_q[i][ORIG_LSB +: PC_WIDTH]));
            pred_vec[i] = cfg_s1_q[i][MODE_BIT] ? |(~diff & mask) : ~|(diff & mask);
        end
    end

    // Walk downwards so the lowest-index match is the last one written.
    always_comb begin
        sel_d     = '0;
        sel_d.thr = thr_s1_q;
        for (int i = int'(BRANCH_COUNT) - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_d.reached = 1'b1;
                sel_d.idx     = ENTRY_WIDTH'(i);
                sel_d.dest    = cfg_s1_q[i][DEST_LSB +: PC_WIDTH];
                sel_d.pred    = pred_vec[i];
                sel_d.pe      = cfg_s1_q[i][PE_BIT];
                sel_d.pt      = cfg_s1_q[i][PT_BIT];
            end
        end
    end

    // Without a completed previous instruction, reuse this thread's last jump decision.
    always_comb begin
        p_sel    = IO_ready_previous ? sel_s3_q.pred : saved_q[sel_s3_q.thr];
        jump_d   = sel_s3_q.reached & p_sel;
        cancel_d = sel_s3_q.reached & sel_s3_q.pe & (sel_s3_q.pt ^ p_sel);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tc_q        <= '0;
            pc_s1_q     <= '0;
            flags_s1_q  <= '0;
            thr_s1_q    <= '0;
            for (int b = 0; b < int'(BRANCH_COUNT); b++) begin
                cfg_s1_q[b] <= '0;
            end
            sel_s2_q    <= '0;
            sel_s3_q    <= '0;
            saved_q     <= '0;
            reached     <= 1'b0;
            destination <= '0;
            entry_index <= '0;
            jump        <= 1'b0;
            cancel      <= 1'b0;
        end else begin
            tc_q        <= tc_d;
            pc_s1_q     <= pc;
            flags_s1_q  <= flags_previous;
            thr_s1_q    <= tc_q;
            for (int b = 0; b < int'(BRANCH_COUNT); b++) begin
                cfg_s1_q[b] <= cfg_q[tc_q][b];
            end
            sel_s2_q    <= sel_d;
            sel_s3_q    <= sel_s2_q;
            saved_q[sel_s3_q.thr] <= jump_d;
            reached     <= sel_s3_q.reached;
            destination <= sel_s3_q.dest;
            entry_index <= sel_s3_q.idx;
            jump        <= jump_d;
            cancel      <= cancel_d;
        end
    end

`ifdef BRANCH_DETECTOR_HIT_COUNT_EN
    logic [15:0] hit_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count_q <= '0;
        end else if (jump && (hit_count_q != 16'hFFFF)) begin
            hit_count_q <= hit_count_q + 16'd1;
        end
    end

    assign hit_count = hit_count_q;
`endif

endmodule
